ysyx_23060332_wbu: RTL

Write-back unit that owns the write port of the 32×32 integer register file. It accepts results from the EXU (ALU) and LSU (load) over valid/ready channels and arbitrates them onto a registered single write port (`waddr`/`wdata`/`reg_wen`). It also keeps a per-register pending-write scoreboard, which the IDU queries for RAW hazards on its two read addresses.

---
 rtl/ysyx_23060332_wbu.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: arbitrates EXU/LSU results onto a registered register-file write port
// and tracks pending writes per register for RAW hazard detection. Bypass: YSYX_23060332_WBU_BYPASS_EN.
module ysyx_23060332_wbu #(
  parameter int SB_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        exu_valid,
  output logic        exu_ready,
  input  logic [4:0]  exu_rd,
  input  logic [31:0] exu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        reg_wen,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        hazard1,
  output logic        hazard2,
`ifdef YSYX_23060332_WBU_BYPASS_EN
  output logic        fwd_valid1,
  output logic        fwd_valid2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
`endif
  output logic        sb_err
);

  typedef enum logic {EMPTY, HELD} state_e;

  state_e            state_q, state_d;
  logic [4:0]        hold_rd_q, hold_rd_d;
  logic [31:0]       hold_data_q, hold_data_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              reg_wen_q, reg_wen_d;
  logic              sb_err_q, sb_err_d;
  logic [SB_W-1:0]   cnt_q [32];
  logic [SB_W-1:0]   cnt_d [32];

  logic exu_fire, lsu_fire, issue_fire;

  assign exu_ready  = (state_q == EMPTY) && rst_n;
  assign lsu_ready  = (state_q == EMPTY) && rst_n;
  assign exu_fire   = exu_valid && exu_ready;
  assign lsu_fire   = lsu_valid && lsu_ready;

  // A write retiring this cycle frees a slot, so a saturated counter may still accept.
  assign issue_ready = (cnt_q[issue_rd] != '1) || (reg_wen_q && (waddr_q == issue_rd));
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

  always_comb begin
    state_d     = state_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    reg_wen_d   = 1'b0;
    case (state_q)
      HELD: begin
        state_d   = EMPTY;
        waddr_d   = hold_rd_q;
        wdata_d   = hold_data_q;
        reg_wen_d = (hold_rd_q != 5'd0);
      end
      default: begin
        if (lsu_fire) begin
          waddr_d   = lsu_rd;
          wdata_d   = lsu_data;
          reg_wen_d = (lsu_rd != 5'd0);
          if (exu_fire) begin
            state_d     = HELD;
            hold_rd_d   = exu_rd;
            hold_data_d = exu_data;
          end
        end else if (exu_fire) begin
          waddr_d   = exu_rd;
          wdata_d   = exu_data;
          reg_wen_d = (exu_rd != 5'd0);
        end
      end
    endcase
  end

  always_comb begin
    logic inc, dec;
    sb_err_d = sb_err_q;
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      inc      = issue_fire && (issue_rd == 5'(r));
      dec      = reg_wen_q && (waddr_q == 5'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + SB_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - SB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      reg_wen_q   <= 1'b0;
      sb_err_q    <= 1'b0;
      cnt_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      reg_wen_q   <= reg_wen_d;
      sb_err_q    <= sb_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign reg_wen = reg_wen_q;
  assign sb_err  = sb_err_q;

`ifdef YSYX_23060332_WBU_BYPASS_EN
  assign fwd_valid1 = reg_wen_q && (waddr_q == raddr1) && (raddr1 != 5'd0);
  assign fwd_valid2 = reg_wen_q && (waddr_q == raddr2) && (raddr2 != 5'd0);
  assign fwd_data1  = wdata_q;
  assign fwd_data2  = wdata_q;
  // The last outstanding write is on the port, so the forwarded value is final.
  assign hazard1 = (cnt_q[raddr1] != '0) && !(fwd_valid1 && (cnt_q[raddr1] == SB_W'(1)));
  assign hazard2 = (cnt_q[raddr2] != '0) && !(fwd_valid2 && (cnt_q[raddr2] == SB_W'(1)));
`else
  assign hazard1 = (cnt_q[raddr1] != '0);
  assign hazard2 = (cnt_q[raddr2] != '0);
`endif

endmodule
